// File: rtl/axilseq_pkg.sv
// +----------------------------------------------------------------------------+
// | axilseq_pkg                                                                |
// | Shared opcodes, error codes, FSM states and table-entry field layout for   |
// | axil_config_sequencer.                                                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package axilseq_pkg;

  localparam logic [1:0] OP_END   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BRESP   = 2'd1;
  localparam logic [1:0] ERR_RRESP   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Entry layout: {op[1:0], addr[31:0], data[31:0]}
  localparam int ENT_W        = 66;
  localparam int ENT_OP_LSB   = 64;
  localparam int ENT_ADDR_LSB = 32;
  localparam int ENT_DATA_LSB = 0;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    WR     = 4'd3,
    WB     = 4'd4,
    RD     = 4'd5,
    RR     = 4'd6,
    NEXT   = 4'd7,
    FINISH = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/axil_config_sequencer.sv
// +----------------------------------------------------------------------------+
// | axil_config_sequencer                                                      |
// | Table-driven AXI4-Lite master: walks WRITE / POLL / END entries from a     |
// | synchronous table. Optional macro AXILSEQ_CONTINUE_ON_ERR_EN keeps walking |
// | after an error, recording only the first one.                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module axil_config_sequencer
  import axilseq_pkg::*;
#(
  parameter int TBL_AW       = 4,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] err_index,
  output logic [TBL_AW-1:0] tbl_index,
  input  logic [ENT_W-1:0]  tbl_entry,
  output logic [31:0]       M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  output logic [2:0]        M_AXI_AWPROT,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [31:0]       M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  output logic [2:0]        M_AXI_ARPROT,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  localparam int                CNT_W    = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(POLL_TIMEOUT);
  localparam logic [TBL_AW-1:0] IDX_MAX  = '1;

`ifdef AXILSEQ_CONTINUE_ON_ERR_EN
  localparam state_t ERR_DEST = NEXT;
`else
  localparam state_t ERR_DEST = FINISH;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TBL_AW-1:0]   r_tbl_index;
  logic [1:0]          r_err_code;
  logic [TBL_AW-1:0]   r_err_index;
  logic [31:0]         r_addr;
  logic [31:0]         r_data;
  logic [CNT_W-1:0]    r_timeout;
  logic                r_aw_done;
  logic                r_w_done;
  logic                w_err_set;
  logic [1:0]          w_err_val;
  logic [1:0]          w_op;
  logic                w_aw_hs;
  logic                w_w_hs;

  assign w_op    = tbl_entry[ENT_OP_LSB +: 2];
  assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_err_val   = ERR_NONE;
    case (r_state)
      IDLE:   if (start) w_state_nxt = FETCH;
      FETCH:  w_state_nxt = DECODE;
      DECODE: begin
        case (w_op)
          OP_WRITE: w_state_nxt = WR;
          OP_POLL:  w_state_nxt = RD;
          OP_END:   w_state_nxt = FINISH;
          default:  w_state_nxt = FINISH;
        endcase
      end
      WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WB;
      end
      WB: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            w_err_set   = 1'b1;
            w_err_val   = ERR_BRESP;
            w_state_nxt = ERR_DEST;
          end else begin
            w_state_nxt = NEXT;
          end
        end
      end
      RD: if (M_AXI_ARREADY) w_state_nxt = RR;
      RR: begin
        // Timeout is judged only once the in-flight response has been consumed.
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            w_err_set   = 1'b1;
            w_err_val   = ERR_RRESP;
            w_state_nxt = ERR_DEST;
          end else if (M_AXI_RDATA == r_data) begin
            w_state_nxt = NEXT;
          end else if (r_timeout <= CNT_W'(1)) begin
            w_err_set   = 1'b1;
            w_err_val   = ERR_TIMEOUT;
            w_state_nxt = ERR_DEST;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      NEXT:    w_state_nxt = (r_tbl_index == IDX_MAX) ? FINISH : FETCH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != IDLE) && (r_state != FINISH);
    done          = (r_state == FINISH);
    M_AXI_AWVALID = (r_state == WR) && !r_aw_done;
    M_AXI_WVALID  = (r_state == WR) && !r_w_done;
    M_AXI_BREADY  = (r_state == WB);
    M_AXI_ARVALID = (r_state == RD);
    M_AXI_RREADY  = (r_state == RR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tbl_index <= '0;
      r_err_code  <= ERR_NONE;
      r_err_index <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_timeout   <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_tbl_index <= '0;
        r_err_code  <= ERR_NONE;
        r_err_index <= '0;
      end
      if (r_state == DECODE) begin
        r_addr    <= tbl_entry[ENT_ADDR_LSB +: 32];
        r_data    <= tbl_entry[ENT_DATA_LSB +: 32];
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_timeout <= CNT_LOAD;
      end
      if (r_state == WR) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if ((r_state == RD || r_state == RR) && r_timeout != '0) begin
        r_timeout <= r_timeout - CNT_W'(1);
      end
      // Only the first error of a walk is kept.
      if (w_err_set && r_err_code == ERR_NONE) begin
        r_err_code  <= w_err_val;
        r_err_index <= r_tbl_index;
      end
      if (r_state == NEXT && r_tbl_index != IDX_MAX) begin
        r_tbl_index <= r_tbl_index + TBL_AW'(1);
      end
    end
  end

  assign err_code     = r_err_code;
  assign err_index    = r_err_index;
  assign tbl_index    = r_tbl_index;
  assign M_AXI_AWADDR = r_addr;
  assign M_AXI_WDATA  = r_data;
  assign M_AXI_ARADDR = r_addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

endmodule

`default_nettype wire
